spr_rename_file: RTL
====================

# spr_rename_file

Parametrised special-purpose register (SPR) file with reservation-station tag tracking for the Tomasulo-style out-of-order core. It holds a configurable set of SPRs (default XER, LR, CTR) addressed by their 10-bit SPR numbers. Each entry tracks a value, a valid bit and the ID of the reservation station producing the pending value. Compared with the single-write-port file, it adds:
- multiple result-bus write ports and multiple rename (update) ports
- same-cycle result forwarding to reads
- a pipeline flush that revalidates all entries
- mapped-address indication and a sticky illegal-access flag

## Interface
- READ_PORTS, 2, number of combinational read ports
- WRITE_PORTS, 2, number of result-bus write ports
- UPDATE_PORTS, 1, number of rename (invalidate/retag) ports
- RS_ID_WIDTH, 5, reservation station ID width
- NUM_SPRS, 3, number of implemented SPRs
- SPR_ADDRS, '{1, 8, 9}, array [0:NUM_SPRS-1] of 10-bit SPR numbers; entry k maps to SPR_ADDRS[k]; entries must be distinct

Ports (all arrays indexed [0:N-1]):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- read_addr  in  [READ_PORTS] x 10  SPR number to read
- read_mapped  out  [READ_PORTS] x 1  address hits an implemented SPR
- read_value_valid  out  [READ_PORTS] x 1  value is final (stored or forwarded)
- read_value  out  [READ_PORTS] x 32  register content
- read_rs_id  out  [READ_PORTS] x RS_ID_WIDTH  producing reservation station ID
- write_addr  in  [WRITE_PORTS] x 10  result target SPR
- write_enable  in  [WRITE_PORTS] x 1  result strobe
- write_value  in  [WRITE_PORTS] x 32  result value
- write_rs_id  in  [WRITE_PORTS] x RS_ID_WIDTH  producing reservation station ID
- update_addr  in  [UPDATE_PORTS] x 10  SPR being renamed
- update_enable  in  [UPDATE_PORTS] x 1  rename strobe
- update_rs_id  in  [UPDATE_PORTS] x RS_ID_WIDTH  new producer ID
- flush  in  1  discard all pending renames
- illegal_access  out  1  sticky; an enabled write/update targeted an unmapped address

## Operation
- Each entry holds {value_valid, value[0:31], rs_id}.
- Reset: every entry is set to valid=1, value=0, rs_id=0, and illegal_access is cleared to 0.
- Read port (combinational), addressing entry k:
  - If the address is unmapped: read_mapped=0, valid=0, value=0, rs_id=0.
  - If entry k is valid: return the stored contents.
  - If entry k is invalid and some enabled write port j has write_addr==SPR_ADDRS[k] and write_rs_id==entry rs_id: forward it, i.e. valid=1, value=write_value[j], rs_id unchanged. The lowest-index matching j wins.
  - Otherwise return the stored contents with valid=0.
  - Updates in the same cycle are not visible to reads.
- Write port j, targeting entry k:
  - Applies only if entry rs_id == write_rs_id[j], regardless of the entry's valid state.
  - Sets value<=write_value[j] and valid<=1.
  - A tag mismatch (stale result after a re-rename) is dropped silently.
  - When several ports hit the same entry, the lowest index wins.
- Update port u, targeting entry k: sets valid<=0 and rs_id<=update_rs_id[u]. When several ports hit the same entry, the highest index wins (higher index = younger instruction).
- Write and update to the same entry in the same cycle:
  - value takes the write value if the tag matched.
  - valid=0 and rs_id come from the update.
- flush:
  - All entries get valid<=1; rs_id and value are kept, except that same-cycle matching writes still land.
  - Updates in a flush cycle are ignored.
- illegal_access is set the cycle after any enabled write or update to an unmapped address. It clears only on rst. Reads never set it.
- rst has priority over everything.

## Timing
- Reads have zero latency (combinational from read_addr and the write ports).
- Writes, updates and flush become visible in stored state one cycle after the rising edge.
- Forwarding makes a result readable in the same cycle it is broadcast.
- A reset asserted mid-operation discards all pending tags at the next edge; inputs in the reset cycle are ignored.

## Test plan
- Reset, then read addresses 1, 8, 9, 5 -> valid=1/value=0/mapped=1 for the first three; address 5 -> mapped=0, valid=0, value=0.
- Update LR (8) with rs 3; next cycle read 8 -> valid=0, rs_id=3. Then write port 1 drives addr 8, rs 3, value 0xDEADBEEF -> same-cycle read valid=1 with 0xDEADBEEF (forwarded); the following cycle the stored value is valid.
- Update CTR (9) with rs 4, then rs 7; write CTR with rs 4 -> dropped, read shows valid=0, rs_id=7. Write with rs 7, value 0x10 -> valid=1, value 0x10.
- Same cycle: write XER with rs 2 / 0x20000000 (matching) and update XER with rs 6 -> next cycle value=0x20000000, valid=0, rs_id=6.
- Rename XER and LR, assert flush together with an update of CTR -> next cycle all valid=1, CTR rs_id unchanged, values unchanged.
- Enabled write to address 300 -> illegal_access=1 next cycle and stays 1 until rst; no entry changes.

Source files
------------

// File: rtl/spr_rename_file.sv
// Special-purpose register file with reservation-station tag tracking: multi-port result
// writes, rename updates, same-cycle forwarding to reads, flush and a sticky illegal flag.
module spr_rename_file #(
    parameter int unsigned READ_PORTS   = 2,
    parameter int unsigned WRITE_PORTS  = 2,
    parameter int unsigned UPDATE_PORTS = 1,
    parameter int unsigned RS_ID_WIDTH  = 5,
    parameter int unsigned NUM_SPRS     = 3,
    parameter logic [9:0]  SPR_ADDRS [NUM_SPRS] = '{10'd1, 10'd8, 10'd9}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             read_addr        [READ_PORTS],
    output logic                   read_mapped      [READ_PORTS],
    output logic                   read_value_valid [READ_PORTS],
    output logic [31:0]            read_value       [READ_PORTS],
    output logic [RS_ID_WIDTH-1:0] read_rs_id       [READ_PORTS],
    input  logic [9:0]             write_addr       [WRITE_PORTS],
    input  logic                   write_enable     [WRITE_PORTS],
    input  logic [31:0]            write_value      [WRITE_PORTS],
    input  logic [RS_ID_WIDTH-1:0] write_rs_id      [WRITE_PORTS],
    input  logic [9:0]             update_addr      [UPDATE_PORTS],
    input  logic                   update_enable    [UPDATE_PORTS],
    input  logic [RS_ID_WIDTH-1:0] update_rs_id     [UPDATE_PORTS],
    input  logic                   flush,
    output logic                   illegal_access
);

    logic                   valid_q [NUM_SPRS];
    logic                   valid_d [NUM_SPRS];
    logic [31:0]            value_q [NUM_SPRS];
    logic [31:0]            value_d [NUM_SPRS];
    logic [RS_ID_WIDTH-1:0] rs_id_q [NUM_SPRS];
    logic [RS_ID_WIDTH-1:0] rs_id_d [NUM_SPRS];
    logic                   illegal_access_q;
    logic                   illegal_access_d;

    // wr_hit[k][j]: write port j carries the result entry k is waiting on
    logic [WRITE_PORTS-1:0] wr_hit [NUM_SPRS];

    function automatic logic is_mapped(input logic [9:0] addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < NUM_SPRS; k++) begin
            if (addr == SPR_ADDRS[k]) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int unsigned k = 0; k < NUM_SPRS; k++) begin
            wr_hit[k] = '0;
            for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
                wr_hit[k][j] = write_enable[j] && (write_addr[j] == SPR_ADDRS[k]) &&
                               (write_rs_id[j] == rs_id_q[k]);
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < READ_PORTS; r++) begin
            read_mapped[r]      = 1'b0;
            read_value_valid[r] = 1'b0;
            read_value[r]       = '0;
            read_rs_id[r]       = '0;
            for (int unsigned k = 0; k < NUM_SPRS; k++) begin
                if (read_addr[r] == SPR_ADDRS[k]) begin
                    read_mapped[r]      = 1'b1;
                    read_value_valid[r] = valid_q[k];
                    read_value[r]       = value_q[k];
                    read_rs_id[r]       = rs_id_q[k];
                    // Walk ports high to low so the lowest matching index is left standing
                    if (!valid_q[k]) begin
                        for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                            if (wr_hit[k][WRITE_PORTS-1-i]) begin
                                read_value_valid[r] = 1'b1;
                                read_value[r]       = write_value[WRITE_PORTS-1-i];
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        valid_d          = valid_q;
        value_d          = value_q;
        rs_id_d          = rs_id_q;
        illegal_access_d = illegal_access_q;
        for (int unsigned k = 0; k < NUM_SPRS; k++) begin
            for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                if (wr_hit[k][WRITE_PORTS-1-i]) begin
                    valid_d[k] = 1'b1;
                    value_d[k] = write_value[WRITE_PORTS-1-i];
                end
            end
            if (flush) begin
                valid_d[k] = 1'b1;
            end else begin
                // Ascending order lets the youngest (highest) update port win
                for (int unsigned u = 0; u < UPDATE_PORTS; u++) begin
                    if (update_enable[u] && (update_addr[u] == SPR_ADDRS[k])) begin
                        valid_d[k] = 1'b0;
                        rs_id_d[k] = update_rs_id[u];
                    end
                end
            end
        end
        for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
            if (write_enable[j] && !is_mapped(write_addr[j])) illegal_access_d = 1'b1;
        end
        for (int unsigned u = 0; u < UPDATE_PORTS; u++) begin
            if (!flush && update_enable[u] && !is_mapped(update_addr[u])) begin
                illegal_access_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_SPRS; k++) begin
                valid_q[k] <= 1'b1;
                value_q[k] <= '0;
                rs_id_q[k] <= '0;
            end
            illegal_access_q <= 1'b0;
        end else begin
            valid_q          <= valid_d;
            value_q          <= value_d;
            rs_id_q          <= rs_id_d;
            illegal_access_q <= illegal_access_d;
        end
    end

    assign illegal_access = illegal_access_q;

endmodule
